// File: rtl/uart_link_pkg.sv
// Shared widths, line levels and FSM encodings for the UART link endpoint.
package uart_link_pkg;

   localparam int unsigned M_DATA_L = 8;
   localparam int unsigned UART_OVS = 16;

   localparam logic UART_STOP_LVL  = 1'b1;
   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   localparam logic [1:0] TxIdle  = 2'd0;
   localparam logic [1:0] TxStart = 2'd1;
   localparam logic [1:0] TxData  = 2'd2;
   localparam logic [1:0] TxStop  = 2'd3;

   localparam logic [2:0] RxIdle  = 3'd0;
   localparam logic [2:0] RxStart = 3'd1;
   localparam logic [2:0] RxData  = 3'd2;
   localparam logic [2:0] RxStop  = 3'd3;
   localparam logic [2:0] RxBreak = 3'd4;

   // Clocks per oversample tick.
   function automatic int unsigned ovs_div(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / (baud * UART_OVS);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty flags and a read word latched on pop.
module uart_fifo #(
   parameter int unsigned ADDR_L = 4,
   parameter int unsigned DATA_L = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_L-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_L-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned Depth = 2 ** ADDR_L;
   localparam logic [ADDR_L:0] CntFull = {1'b1, {ADDR_L{1'b0}}};

   logic [DATA_L-1:0] mem_q [Depth];
   logic [ADDR_L-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_L:0]   cnt_q, cnt_d;
   logic              full_q, empty_q;
   logic [DATA_L-1:0] dout_q;
   logic              do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         dout_q   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            dout_q   <= mem_q[rd_ptr_q];
         end
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CntFull);
         empty_q <= (cnt_d == '0);
      end
   end

   assign dout_o  = dout_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/uart_link.sv
// 8N1 UART endpoint: 4-phase byte handshakes to the controller, TX/RX FIFOs,
// oversample tick generator and the serialiser/deserialiser FSMs.
module uart_link
   import uart_link_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 100000000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned FIFO_ADDR_L = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [M_DATA_L-1:0] tx_data_i,
   input  logic                tx_we_i,
   output logic                tx_wack_o,
   output logic                tx_wa_o,
   output logic [M_DATA_L-1:0] rx_data_o,
   input  logic                rx_re_i,
   output logic                rx_rack_o,
   output logic                rx_ra_o,
   output logic                uart_tx_o,
   input  logic                uart_rx_i,
   output logic                rx_ferr_o,
   output logic                rx_ovr_o
);

   localparam int unsigned OVS_DIV = ovs_div(CLK_FREQ, BAUD);
   localparam int unsigned TickW   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
   localparam logic [TickW-1:0] TickMax = TickW'(OVS_DIV - 1);

   logic [TickW-1:0] tick_cnt_q;
   logic             tick;

   logic                tx_push, tx_pop, tx_full, tx_empty;
   logic [M_DATA_L-1:0] tx_dout;
   logic                rx_push, rx_pop, rx_full, rx_empty;

   logic tx_wack_q, tx_wack_d, rx_rack_q, rx_rack_d;

   logic [1:0]          tx_state_q, tx_state_d;
   logic [3:0]          tx_cnt_q, tx_cnt_d;
   logic [2:0]          tx_bit_q, tx_bit_d;
   logic [M_DATA_L-1:0] tx_shift_q, tx_shift_d;
   logic                tx_line_q, tx_line_d;

   logic                rx_s1_q, rx_s2_q, rx_prev_q;
   logic [2:0]          rx_state_q, rx_state_d;
   logic [3:0]          rx_cnt_q, rx_cnt_d;
   logic [2:0]          rx_bit_q, rx_bit_d;
   logic [M_DATA_L-1:0] rx_shift_q, rx_shift_d;
   logic                rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

   assign tick = (tick_cnt_q == TickMax);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      end
   end

   // One push per tx_we high period, one pop per rx_re high period.
   assign tx_push = tx_we_i & ~tx_wack_q & ~tx_full;
   assign rx_pop  = rx_re_i & ~rx_rack_q & ~rx_empty;

   always_comb begin
      tx_wack_d = tx_wack_q;
      if (tx_push) begin
         tx_wack_d = 1'b1;
      end else if (!tx_we_i) begin
         tx_wack_d = 1'b0;
      end
      rx_rack_d = rx_rack_q;
      if (rx_pop) begin
         rx_rack_d = 1'b1;
      end else if (!rx_re_i) begin
         rx_rack_d = 1'b0;
      end
   end

   // The popped byte appears on tx_dout during START and is loaded when START ends.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      tx_pop     = 1'b0;
      if (tick) begin
         case (tx_state_q)
            TxIdle: begin
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_state_d = TxStart;
                  tx_cnt_d   = '0;
                  tx_line_d  = UART_START_LVL;
               end
            end
            TxStart: begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == 4'd15) begin
                  tx_state_d = TxData;
                  tx_shift_d = tx_dout;
                  tx_line_d  = tx_dout[0];
                  tx_bit_d   = '0;
               end
            end
            TxData: begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == 4'd15) begin
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = TxStop;
                     tx_line_d  = UART_STOP_LVL;
                  end else begin
                     tx_shift_d = {1'b0, tx_shift_q[M_DATA_L-1:1]};
                     tx_line_d  = tx_shift_q[1];
                     tx_bit_d   = tx_bit_q + 3'd1;
                  end
               end
            end
            TxStop: begin
               tx_cnt_d = tx_cnt_q + 4'd1;
               if (tx_cnt_q == 4'd15) begin
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_state_d = TxStart;
                     tx_line_d  = UART_START_LVL;
                  end else begin
                     tx_state_d = TxIdle;
                     tx_line_d  = UART_IDLE_LVL;
                  end
               end
            end
            default: begin
               tx_state_d = TxIdle;
               tx_line_d  = UART_IDLE_LVL;
            end
         endcase
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovr_d   = rx_ovr_q;
      rx_push    = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (tick) begin
               rx_cnt_d = rx_cnt_q + 4'd1;
               if (rx_cnt_q == 4'd7) begin
                  if (rx_s2_q) begin
                     rx_state_d = RxIdle;
                  end else begin
                     rx_state_d = RxData;
                     rx_cnt_d   = '0;
                     rx_bit_d   = '0;
                  end
               end
            end
         end
         RxData: begin
            if (tick) begin
               rx_cnt_d = rx_cnt_q + 4'd1;
               if (rx_cnt_q == 4'd15) begin
                  rx_shift_d = {rx_s2_q, rx_shift_q[M_DATA_L-1:1]};
                  rx_bit_d   = rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_d = RxStop;
                  end
               end
            end
         end
         RxStop: begin
            if (tick) begin
               rx_cnt_d = rx_cnt_q + 4'd1;
               if (rx_cnt_q == 4'd15) begin
                  if (rx_s2_q == UART_STOP_LVL) begin
                     rx_push    = 1'b1;
                     rx_ovr_d   = rx_ovr_q | rx_full;
                     rx_state_d = RxIdle;
                  end else begin
                     rx_ferr_d  = 1'b1;
                     rx_state_d = RxBreak;
                  end
               end
            end
         end
         RxBreak: begin
            if (rx_s2_q) begin
               rx_state_d = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_wack_q  <= 1'b0;
         rx_rack_q  <= 1'b0;
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= UART_IDLE_LVL;
         rx_s1_q    <= UART_IDLE_LVL;
         rx_s2_q    <= UART_IDLE_LVL;
         rx_prev_q  <= UART_IDLE_LVL;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         tx_wack_q  <= tx_wack_d;
         rx_rack_q  <= rx_rack_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
         rx_s1_q    <= uart_rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   uart_fifo #(
      .ADDR_L(FIFO_ADDR_L),
      .DATA_L(M_DATA_L)
   ) u_tx_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (tx_push),
      .din_i  (tx_data_i),
      .pop_i  (tx_pop),
      .dout_o (tx_dout),
      .full_o (tx_full),
      .empty_o(tx_empty)
   );

   uart_fifo #(
      .ADDR_L(FIFO_ADDR_L),
      .DATA_L(M_DATA_L)
   ) u_rx_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (rx_push),
      .din_i  (rx_shift_q),
      .pop_i  (rx_pop),
      .dout_o (rx_data_o),
      .full_o (rx_full),
      .empty_o(rx_empty)
   );

   assign tx_wack_o = tx_wack_q;
   assign rx_rack_o = rx_rack_q;
   assign tx_wa_o   = ~tx_full;
   assign rx_ra_o   = ~rx_empty;
   assign uart_tx_o = tx_line_q;
   assign rx_ferr_o = rx_ferr_q;
   assign rx_ovr_o  = rx_ovr_q;

endmodule

// File: tb/tb_uart_link.sv
// Scoreboard bench for uart_link: 16 clk per bit, line monitors check bytes in order.
`timescale 1ns/1ps
module tb_uart_link;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_we = 1'b0;
   logic       tx_wack, tx_wa;
   logic [7:0] rx_data;
   logic       rx_re = 1'b0;
   logic       rx_rack, rx_ra;
   logic       uart_tx;
   logic       uart_rx = 1'b1;
   logic       rx_ferr, rx_ovr;

   always #5 clk = ~clk;

   uart_link #(
      .CLK_FREQ   (1600000),
      .BAUD       (100000),
      .FIFO_ADDR_L(4)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .tx_data_i(tx_data),
      .tx_we_i  (tx_we),
      .tx_wack_o(tx_wack),
      .tx_wa_o  (tx_wa),
      .rx_data_o(rx_data),
      .rx_re_i  (rx_re),
      .rx_rack_o(rx_rack),
      .rx_ra_o  (rx_ra),
      .uart_tx_o(uart_tx),
      .uart_rx_i(uart_rx),
      .rx_ferr_o(rx_ferr),
      .rx_ovr_o (rx_ovr)
   );

   int         n_tests = 0;
   int         n_fail = 0;
   int         rst_epoch = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic       rack_prev = 1'b0;

   always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s", name, what);
   endtask

   // TX line monitor: finds start bits, samples mid-bit, pops the expected byte.
   initial begin : tx_mon
      logic [7:0] b;
      logic       st;
      int         ep;
      forever begin
         @(negedge clk);
         if (rst_n && uart_tx == 1'b0) begin
            ep = rst_epoch;
            repeat (7) @(negedge clk);
            st = uart_tx;
            for (int i = 0; i < 8; i++) begin
               repeat (16) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (16) @(negedge clk);
            if (ep == rst_epoch && rst_n) begin
               check("tx_start_bit", {31'd0, st}, 32'd0);
               check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
               if (tx_exp.size() == 0) fail_now("tx_frame", $sformatf("got %02h, expected none", b));
               else check("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
            end
         end
      end
   end

   // RX handshake monitor: every rising rx_rack presents the next expected byte.
   initial begin : rx_mon
      forever begin
         @(negedge clk);
         if (rx_rack && !rack_prev) begin
            if (rx_exp.size() == 0) fail_now("rx_frame", $sformatf("got %02h, expected none", rx_data));
            else check("rx_byte", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
         end
         rack_prev = rx_rack;
      end
   end

   task automatic write_byte(input logic [7:0] b);
      int k;
      tx_data = b;
      tx_we = 1'b1;
      k = 0;
      while (!tx_wack && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!tx_wack) fail_now("write_timeout", "tx_wack got 0, expected 1");
      else tx_exp.push_back(b);
      tx_we = 1'b0;
      k = 0;
      while (tx_wack && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (tx_wack) fail_now("wack_release", "tx_wack got 1, expected 0");
   endtask

   task automatic read_byte();
      int k;
      rx_re = 1'b1;
      k = 0;
      while (!rx_rack && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!rx_rack) fail_now("read_timeout", "rx_rack got 0, expected 1");
      rx_re = 1'b0;
      k = 0;
      while (rx_rack && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (rx_rack) fail_now("rack_release", "rx_rack got 1, expected 0");
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         repeat (16) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask

   task automatic wait_tx_drain(input int bound);
      int k;
      k = 0;
      while (tx_exp.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (tx_exp.size() != 0) fail_now("tx_drain", $sformatf("%0d bytes unsent, expected 0", tx_exp.size()));
      repeat (20) @(negedge clk);
   endtask

   initial begin : main
      logic [9:0] a5_bits;
      int         k;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tx_wack", {31'd0, tx_wack}, 32'd0);
      check("rst_rx_rack", {31'd0, rx_rack}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_rx_ferr", {31'd0, rx_ferr}, 32'd0);
      check("rst_rx_ovr", {31'd0, rx_ovr}, 32'd0);
      check("rst_tx_wa", {31'd0, tx_wa}, 32'd1);
      check("rst_rx_ra", {31'd0, rx_ra}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single byte 0xA5: handshake latency and exact line pattern
      a5_bits = 10'b1101001010;
      tx_data = 8'hA5;
      tx_we = 1'b1;
      @(negedge clk);
      check("tx_wack_latency", {31'd0, tx_wack}, 32'd1);
      tx_exp.push_back(8'hA5);
      tx_we = 1'b0;
      k = 0;
      while (tx_wack && k < 50) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (uart_tx && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (7) @(negedge clk);
      check("a5_bit0", {31'd0, uart_tx}, {31'd0, a5_bits[0]});
      for (int i = 1; i < 10; i++) begin
         repeat (16) @(negedge clk);
         check($sformatf("a5_bit%0d", i), {31'd0, uart_tx}, {31'd0, a5_bits[i]});
      end
      check("a5_tx_wa", {31'd0, tx_wa}, 32'd1);
      wait_tx_drain(400);

      // Fill the TX FIFO while the line is busy; the extra byte must stall
      for (int i = 0; i <= 16; i++) write_byte(8'(i));
      tx_data = 8'h11;
      tx_we = 1'b1;
      repeat (20) @(negedge clk);
      check("tx_wack_blocked", {31'd0, tx_wack}, 32'd0);
      check("tx_wa_full", {31'd0, tx_wa}, 32'd0);
      write_byte(8'h11);
      wait_tx_drain(3500);

      // Receive 0x3C with latency window
      rx_exp.push_back(8'h3C);
      fork
         send_frame(8'h3C, 1'b1);
         begin
            repeat (145) @(negedge clk);
            check("rx_ra_early", {31'd0, rx_ra}, 32'd0);
            repeat (20) @(negedge clk);
            check("rx_ra_late", {31'd0, rx_ra}, 32'd1);
         end
      join
      read_byte();
      check("rx_ra_after_read", {31'd0, rx_ra}, 32'd0);

      // Framing error then a good byte
      send_frame(8'hF0, 1'b0);
      repeat (20) @(negedge clk);
      check("ferr_set", {31'd0, rx_ferr}, 32'd1);
      check("ferr_no_push", {31'd0, rx_ra}, 32'd0);
      rx_exp.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      repeat (20) @(negedge clk);
      check("rx_55_ready", {31'd0, rx_ra}, 32'd1);
      read_byte();

      // Glitch is ignored; then overrun on 17 unread frames
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_rx_ra", {31'd0, rx_ra}, 32'd0);
      check("glitch_rx_ovr", {31'd0, rx_ovr}, 32'd0);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) rx_exp.push_back(8'h80 + 8'(i));
         send_frame(8'h80 + 8'(i), 1'b1);
      end
      repeat (20) @(negedge clk);
      check("ovr_set", {31'd0, rx_ovr}, 32'd1);
      check("ovr_rx_ra", {31'd0, rx_ra}, 32'd1);
      for (int i = 0; i < 15; i++) read_byte();
      check("ovr_one_left", {31'd0, rx_ra}, 32'd1);

      // Reset in the middle of a TX start bit
      write_byte(8'hC3);
      repeat (8) @(negedge clk);
      check("tx_busy_pre_rst", {31'd0, uart_tx}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_mid_tx_wa", {31'd0, tx_wa}, 32'd1);
      check("rst_mid_rx_ra", {31'd0, rx_ra}, 32'd0);
      check("rst_mid_ferr", {31'd0, rx_ferr}, 32'd0);
      check("rst_mid_ovr", {31'd0, rx_ovr}, 32'd0);
      tx_exp.delete();
      rx_exp.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      write_byte(8'h5A);
      wait_tx_drain(400);

      check("tx_queue_empty", tx_exp.size(), 32'd0);
      check("rx_queue_empty", rx_exp.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
